dlbf_coeffs_seq: RTL

Run sequencer for a bank of `NUM_CH` DLBF coefficient streamers (RAM-to-AXI4-Stream replay engines). It latches one run configuration (block size, iteration count, RAM rollover address) and broadcasts it to every streamer. It then pulses the shared streamer reset, arms `go` on the enabled channels and collects their `done` flags. On completion, abort or timeout it retires the run and reports status to the control register block.

---
 rtl/dlbf_coeffs_seq.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/dlbf_coeffs_seq.sv
// Run sequencer for a bank of DLBF coefficient streamers: latches a run
// configuration, resets/arms the streamers, collects done flags and retires the run.
module dlbf_coeffs_seq #(
  parameter int unsigned NUM_CH       = 8,
  parameter int unsigned RST_CYCLES   = 8,
  parameter int unsigned ARM_CYCLES   = 4,
  parameter int unsigned DRAIN_CYCLES = 8,
  parameter logic [31:0] TIMEOUT      = 32'd0
) (
  input  logic              m_axis_clk,
  input  logic              m_axis_rst_n,
  input  logic              start,
  input  logic              stop,
  input  logic [NUM_CH-1:0] ch_enable,
  input  logic [11:0]       cfg_block_size,
  input  logic [11:0]       cfg_niter,
  input  logic [15:0]       cfg_rollover_addr,
  input  logic [NUM_CH-1:0] done_in,
  output logic              stream_rst,
  output logic [NUM_CH-1:0] go,
  output logic [11:0]       block_size,
  output logic [11:0]       niter,
  output logic [15:0]       rollover_addr,
  output logic              busy,
  output logic              run_done,
  output logic              irq,
  output logic [1:0]        status,
  output logic [15:0]       run_count
);

  typedef enum logic [2:0] {
    S_IDLE, S_RESET, S_ARM, S_RUN, S_DRAIN, S_DONE
  } state_t;

  localparam logic [1:0] ST_OK      = 2'b00;
  localparam logic [1:0] ST_ABORT   = 2'b01;
  localparam logic [1:0] ST_TIMEOUT = 2'b10;

  localparam logic [31:0] RST_LAST   = 32'(RST_CYCLES - 1);
  localparam logic [31:0] ARM_LAST   = 32'(ARM_CYCLES - 1);
  localparam logic [31:0] DRAIN_LAST = 32'(DRAIN_CYCLES - 1);

  state_t            state_q, state_d;
  logic [31:0]       cnt_q;
  logic [NUM_CH-1:0] en_q, done_q;
  logic [1:0]        status_d;
  logic              start_ok, all_done, timeout_hit, idle_like, enter_done;

  // NOTE: every signal written here gets a default first, otherwise paths
  // that skip an assignment infer latches.
  always_comb begin
    state_d     = state_q;
    status_d    = status;
    idle_like   = (state_q == S_IDLE) || (state_q == S_DONE);
    start_ok    = start & ~stop & (|ch_enable);
    // Completion sees this cycle's done_in so go drops on the very next edge.
    all_done    = &(done_q | (done_in & en_q) | ~en_q);
    timeout_hit = (TIMEOUT != 32'd0) && (niter != 12'd0) &&
                  (cnt_q == TIMEOUT - 32'd1);

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start_ok) begin
          state_d  = S_RESET;
          status_d = ST_OK;
        end
      end
      S_RESET: begin
        if (cnt_q == RST_LAST) state_d = S_ARM;
      end
      S_ARM: begin
        if (stop) begin
          state_d  = S_DRAIN;
          status_d = ST_ABORT;
        end else if (cnt_q == ARM_LAST) begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (stop) begin
          state_d  = S_DRAIN;
          status_d = ST_ABORT;
        end else if (all_done) begin
          state_d  = S_DRAIN;
          status_d = ST_OK;
        end else if (timeout_hit) begin
          state_d  = S_DRAIN;
          status_d = ST_TIMEOUT;
        end
      end
      S_DRAIN: begin
        if (cnt_q == DRAIN_LAST) state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase

    enter_done = (state_d == S_DONE) && (state_q != S_DONE);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge m_axis_clk or negedge m_axis_rst_n) begin
    if (!m_axis_rst_n) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      en_q          <= '0;
      done_q        <= '0;
      stream_rst    <= 1'b0;
      go            <= '0;
      block_size    <= '0;
      niter         <= '0;
      rollover_addr <= '0;
      busy          <= 1'b0;
      run_done      <= 1'b0;
      irq           <= 1'b0;
      status        <= ST_OK;
      run_count     <= '0;
    end else begin
      state_q    <= state_d;
      // One counter serves the phase lengths and the RUN timeout.
      cnt_q      <= (state_d != state_q) ? '0 : cnt_q + 32'd1;
      status     <= status_d;
      stream_rst <= (state_d == S_RESET);
      go         <= (state_d == S_RUN) ? en_q : '0;
      busy       <= (state_d != S_IDLE) && (state_d != S_DONE);
      irq        <= enter_done;

      if (state_q == S_RUN) done_q <= done_q | (done_in & en_q);

      if (idle_like && start_ok) begin
        en_q          <= ch_enable;
        block_size    <= cfg_block_size;
        niter         <= cfg_niter;
        rollover_addr <= cfg_rollover_addr;
        done_q        <= '0;
        run_done      <= 1'b0;
      end

      if (enter_done) begin
        run_done <= 1'b1;
        if (status == ST_OK) run_count <= run_count + 16'd1;
      end
    end
  end

endmodule
